// File: rtl/mac_seq_if.sv
// Job, operand-stream, MAC-side and result signals of the mac_seq sequencer.
// The slave modport is the sequencer's view; master is the driver/consumer side.
interface mac_seq_if #(
  parameter int DW    = 8,
  parameter int AW    = 16,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic [DW-1:0]    mac_a;
  logic [DW-1:0]    mac_b;
  logic             mac_clr;
  logic [AW-1:0]    mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [AW-1:0]    res_data;
  logic             res_err;

  modport slave (
    input  start, len, in_valid, in_a, in_b, mac_out, res_ready,
    output busy, in_ready, mac_a, mac_b, mac_clr, res_valid, res_data, res_err
  );

  modport master (
    output start, len, in_valid, in_a, in_b, mac_out, res_ready,
    input  busy, in_ready, mac_a, mac_b, mac_clr, res_valid, res_data, res_err
  );
endinterface

// File: rtl/mac_seq.sv
// Job sequencer for the mult_acc datapath: clears the accumulator, streams LEN pairs, returns the sum.
// Optional stall timeout: define MAC_SEQ_TIMEOUT_EN (abort to DONE with res_err after TO_CYC idle RUN cycles).
module mac_seq #(
  parameter int DW     = 8,
  parameter int AW     = 16,
  parameter int LEN_W  = 8,
  parameter int TO_CYC = 255
) (
  input logic     clk,
  input logic     aclr,
  mac_seq_if.slave io
);

  if (TO_CYC < 1 || AW < DW) begin : g_param_check
    $error("mac_seq: TO_CYC must be >= 1 and AW >= DW");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [DW-1:0]    mac_a_q, mac_b_q;
  logic             mac_clr_q;
  logic             res_valid_q;
  logic             accept;
  logic             res_hs;
  logic             timeout;

  assign accept      = (state == S_RUN) && io.in_valid;
  assign res_hs      = res_valid_q && io.res_ready;
  assign io.in_ready = (state == S_RUN);
  assign io.busy     = (state != S_IDLE);
  assign io.mac_a    = mac_a_q;
  assign io.mac_b    = mac_b_q;
  assign io.mac_clr  = mac_clr_q;
  assign io.res_valid = res_valid_q;
  // The MAC holds its value in DONE because operands are zero there.
  assign io.res_data = io.mac_out;

`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0] stall_cnt;
  logic          res_err_q;

  assign timeout    = (state == S_RUN) && !io.in_valid && (stall_cnt == CW'(TO_CYC - 1));
  assign io.res_err = res_err_q;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      stall_cnt <= '0;
      res_err_q <= 1'b0;
    end else begin
      if (state != S_RUN || accept) stall_cnt <= '0;
      else                          stall_cnt <= stall_cnt + 1'b1;
      if (timeout)     res_err_q <= 1'b1;
      else if (res_hs) res_err_q <= 1'b0;
    end
  end
`else
  assign timeout    = 1'b0;
  assign io.res_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n = state;
    rem_n   = rem;
    unique case (state)
      S_IDLE: begin
        if (io.start) begin
          rem_n   = io.len;
          state_n = S_CLEAR;
        end
      end
      S_CLEAR: state_n = (rem != '0) ? S_RUN : S_DONE;
      S_RUN: begin
        if (accept) begin
          rem_n = rem - 1'b1;
          if (rem == LEN_W'(1)) state_n = S_DRAIN;
        end else if (timeout) begin
          state_n = S_DONE;
        end
      end
      S_DRAIN: state_n = S_DONE;
      S_DONE:  if (res_hs) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state       <= S_IDLE;
      rem         <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_clr_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= state_n;
      rem       <= rem_n;
      mac_clr_q <= (state_n == S_CLEAR);
      // Zero operands whenever nothing is accepted: the MAC accumulates every clock.
      mac_a_q   <= accept ? io.in_a : '0;
      mac_b_q   <= accept ? io.in_b : '0;
      // Result valid trails DONE entry by one edge, so the final accumulate has settled.
      res_valid_q <= (state == S_DONE) && !res_hs;
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq with a behavioural mult_acc model; expected sums come
// from plain arithmetic over the pairs sent.
module tb_mac_seq;
  localparam int DW = 8, AW = 16, LEN_W = 8;
`ifdef MAC_SEQ_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif

  logic clk = 1'b0;
  logic aclr;
  logic [AW-1:0] acc;
  logic mac_aclr;
  int n_total = 0;
  int n_pass  = 0;
  int op_a[8];
  int op_b[8];
  logic [AW-1:0] got;

  mac_seq_if #(.DW(DW), .AW(AW), .LEN_W(LEN_W)) io ();

  mac_seq #(.DW(DW), .AW(AW), .LEN_W(LEN_W), .TO_CYC(TO)) dut (
    .clk (clk),
    .aclr(aclr),
    .io  (io)
  );

  always #5 clk = ~clk;

  // Accumulator of the downstream MAC: clears asynchronously on aclr|mac_clr, else adds a*b.
  assign mac_aclr   = aclr | io.mac_clr;
  assign io.mac_out = acc;
  always_ff @(posedge clk or posedge mac_aclr) begin
    if (mac_aclr) acc <= '0;
    else          acc <= acc + AW'(io.mac_a) * AW'(io.mac_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic run_job(input int n, input int gap, input int hold, output logic [AW-1:0] res);
    int exp_sum = 0;
    int waited;
    bit rdy;
    io.len   = LEN_W'(n);
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
    check("clear_mac_clr", io.mac_clr, 1);
    check("clear_busy", io.busy, 1);
    check("clear_in_ready", io.in_ready, 0);
    check("clear_mac_a", io.mac_a, 0);
    for (int i = 0; i < n; i++) begin
      io.in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        check("gap_mac_a", io.mac_a, 0);
        check("gap_mac_b", io.mac_b, 0);
      end
      io.in_valid = 1'b1;
      io.in_a = DW'(op_a[i]);
      io.in_b = DW'(op_b[i]);
      waited = 0;
      do begin
        rdy = io.in_ready;
        tick();
        waited++;
      end while (!rdy && waited < 20);
      check("accept_in_time", 32'(rdy), 1);
      check("op_a_loaded", io.mac_a, 32'(op_a[i]));
      check("op_b_loaded", io.mac_b, 32'(op_b[i]));
      exp_sum = (exp_sum + op_a[i] * op_b[i]) % (1 << AW);
    end
    io.in_valid = 1'b0;
    check("t0_res_valid", io.res_valid, 0);
    check("t0_in_ready", io.in_ready, 0);
    tick();
    check("t1_res_valid", io.res_valid, 0);
    check("t1_mac_a_zero", io.mac_a, 0);
    tick();
    check("t2_res_valid", io.res_valid, 1);
    check("res_data", io.res_data, 32'(exp_sum));
    check("res_err_clear", io.res_err, 0);
    res = io.res_data;
    io.start = 1'b1;  // must be ignored while DONE
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", io.res_valid, 1);
      check("hold_data", io.res_data, 32'(exp_sum));
    end
    io.res_ready = 1'b1;
    tick();
    io.res_ready = 1'b0;
    io.start = 1'b0;
    check("idle_busy", io.busy, 0);
    check("idle_res_valid", io.res_valid, 0);
  endtask

  initial begin
    aclr = 1'b1;
    io.start = 1'b0; io.len = '0; io.in_valid = 1'b0;
    io.in_a = '0; io.in_b = '0; io.res_ready = 1'b0;
    tick(); tick();
    check("rst_busy", io.busy, 0);
    check("rst_in_ready", io.in_ready, 0);
    check("rst_mac_a", io.mac_a, 0);
    check("rst_mac_b", io.mac_b, 0);
    check("rst_mac_clr", io.mac_clr, 0);
    check("rst_res_valid", io.res_valid, 0);
    check("rst_res_err", io.res_err, 0);
    aclr = 1'b0;
    tick();

    // in_valid while IDLE consumes nothing
    io.in_valid = 1'b1; io.in_a = 8'd5; io.in_b = 8'd5;
    tick();
    check("idle_in_ready", io.in_ready, 0);
    check("idle_mac_a", io.mac_a, 0);
    check("idle_busy0", io.busy, 0);
    io.in_valid = 1'b0;

    op_a[0] = 2; op_b[0] = 3; op_a[1] = 4; op_b[1] = 5; op_a[2] = 1; op_b[2] = 1;
    run_job(3, 0, 0, got);
    check("vec_001b", got, 32'h001B);

    run_job(0, 0, 1, got);
    check("vec_len0", got, 32'h0000);

    op_a[0] = 10; op_b[0] = 11; op_a[1] = 12; op_b[1] = 13;
    run_job(2, 3, 5, got);
    check("vec_gaps", got, 32'd266);

    op_a[0] = 255; op_b[0] = 255; op_a[1] = 255; op_b[1] = 255;
    run_job(2, 0, 0, got);
    check("vec_fc02", got, 32'hFC02);

    // Reset mid-job with two pairs still outstanding
    io.len = 8'd3; io.start = 1'b1;
    tick();
    io.start = 1'b0;
    io.in_valid = 1'b1; io.in_a = 8'd9; io.in_b = 8'd9;
    tick();  // CLEAR exit, nothing accepted
    tick();  // first pair accepted, rem=2
    check("pre_abort_mac_a", io.mac_a, 9);
    io.in_valid = 1'b0;
    aclr = 1'b1;
    #1;
    check("abort_busy", io.busy, 0);
    check("abort_in_ready", io.in_ready, 0);
    check("abort_mac_a", io.mac_a, 0);
    check("abort_mac_b", io.mac_b, 0);
    check("abort_res_valid", io.res_valid, 0);
    check("abort_mac_out", io.mac_out, 0);
    #2 aclr = 1'b0;
    tick();
    check("post_abort_busy", io.busy, 0);
    check("post_abort_res_valid", io.res_valid, 0);

    for (int j = 0; j < 6; j++) begin
      int n, gap, hold;
      n = int'($urandom_range(1, 6));
      gap = int'($urandom_range(0, 2));
      hold = int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        op_a[i] = int'($urandom_range(0, 255));
        op_b[i] = int'($urandom_range(0, 255));
      end
      run_job(n, gap, hold, got);
    end

`ifdef MAC_SEQ_TIMEOUT_EN
    io.len = 8'd4; io.start = 1'b1;
    tick();
    io.start = 1'b0;
    tick();
    check("to_run_ready", io.in_ready, 1);
    io.in_valid = 1'b1; io.in_a = 8'd7; io.in_b = 8'd6;
    tick();
    io.in_valid = 1'b0;
    check("to_accept_a", io.mac_a, 7);
    for (int k = 1; k < TO; k++) tick();
    check("to_still_run", io.in_ready, 1);
    tick();
    check("to_left_run", io.in_ready, 0);
    check("to_busy", io.busy, 1);
    tick();
    check("to_res_valid", io.res_valid, 1);
    check("to_res_err", io.res_err, 1);
    check("to_res_data", io.res_data, 32'h002A);
    io.res_ready = 1'b1;
    tick();
    io.res_ready = 1'b0;
    check("to_err_cleared", io.res_err, 0);
    check("to_idle", io.busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Job sequencer for the 8x8 multiply-accumulate datapath (mult_acc).
- Accepts a dot-product job of LEN operand pairs, clears the accumulator, and streams pairs into the MAC under a valid/ready handshake.
- Drives zero operands whenever no pair is being issued, because the MAC accumulates every clock and has no enable.
- Presents the final accumulator value to a downstream consumer with a valid/ready handshake.

Parameters:
- DW, 8, operand width; must match MAC inputs.
- AW, 16, accumulator/result width; must match MAC output.
- LEN_W, 8, job-length width; max job = 2^LEN_W-1 pairs.
- TO_CYC, 255, stall-timeout cycle count; used only with MAC_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- aclr  in  1  asynchronous active-high reset; the same net drives the MAC's aclr.
- start  in  1  job request, sampled in IDLE only.
- len  in  LEN_W  pair count, captured with start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted this cycle when in_valid=1.
- in_a  in  DW  operand A.
- in_b  in  DW  operand B.
- mac_a  out  DW  registered operand to MAC in_a.
- mac_b  out  DW  registered operand to MAC in_b.
- mac_clr  out  1  registered one-cycle accumulator clear; ORed with aclr at the MAC's aclr.
- mac_out  in  AW  MAC accumulator value.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  AW  result; equals mac_out while res_valid=1.
- res_err  out  1  job aborted by timeout; tied 0 when the macro is undefined.

Behaviour:
- Reset (aclr=1, async): state=IDLE; rem=0; outputs busy, in_ready, mac_a, mac_b, mac_clr, res_valid, res_err all 0.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: on start=1, capture len into rem and go to CLEAR. While busy, start is ignored.
- CLEAR: lasts exactly 1 cycle with mac_clr=1 and mac_a=mac_b=0.
  - rem!=0 → RUN.
  - rem==0 → DONE; res_data=0.
- RUN: in_ready=1 (combinational from state).
  - On in_valid&in_ready at edge t: mac_a/mac_b load in_a/in_b and rem decrements.
  - With no handshake, mac_a/mac_b load 0.
  - Accepting the pair with rem==1 → DRAIN.
- DRAIN: lasts 1 cycle; mac_a/mac_b hold the last pair, which the MAC accumulates at the DRAIN exit edge; operands then return to 0 → DONE.
- DONE: res_valid=1; res_data=mac_out, which is stable because operands are 0.
  - res_valid holds until res_ready=1; on that edge → IDLE.
  - A start asserted in the same cycle is ignored.
- Latency: start edge s → in_ready high from edge s+1. Last accept at edge t → res_valid high from edge t+2.
- Arithmetic: the result is the sum of a_i*b_i modulo 2^AW; wrap is silent and the controller does not detect it.
- mac_a/mac_b are never nonzero outside RUN and DRAIN.
- in_valid outside RUN is ignored; no pair is consumed.
- aclr mid-job: immediate IDLE and the MAC is cleared; the partial result is discarded and no res_valid is issued.

Optional Feature:
- Macro MAC_SEQ_TIMEOUT_EN.
- Defined:
  - A stall counter resets on each accept and counts RUN cycles with in_valid=0.
  - When it reaches TO_CYC, go to DONE with res_err=1 and res_data = the partial sum. No DRAIN is needed because the last accepted pair was already accumulated.
  - res_err clears when the result handshake completes.
- Undefined: no counter; RUN waits indefinitely; res_err is constant 0.

Test Plan:
- Assert aclr during RUN with rem=2 → next sample: busy=0, in_ready=0, mac_a=mac_b=0, res_valid=0; mac_out=0; a new start then works normally.
- len=3; pairs (2,3),(4,5),(1,1) back-to-back → mac_clr pulses 1 cycle; res_data=0x001B; res_valid rises 2 edges after the third accept.
- len=0 → CLEAR 1 cycle, then DONE with res_data=0x0000; in_ready never asserts.
- len=2 with in_valid gaps of 3 cycles, and res_ready held low 5 cycles after res_valid → mac_a/mac_b=0 during gaps; res_data stays at the same value for all 5 cycles; IDLE after the handshake.
- len=2; pairs (255,255),(255,255) → res_data=0xFC02 (130050 mod 65536).
- MAC_SEQ_TIMEOUT_EN defined, TO_CYC=10, len=4, one pair (7,6) then in_valid=0 → DONE after 10 stall cycles; res_err=1, res_data=0x002A.
